// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write-side and read-side handlers of the async FIFO.
package fifo_pkg;

    localparam int PTR_WIDTH_DFLT = 3;

    typedef logic [PTR_WIDTH_DFLT:0] ptr_t;

    function automatic int depth_of(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    // Generic over widths up to 32: callers zero-extend and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_ptr_handler_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/wr_ptr_handler.sv
// Write-domain pointer and flag logic of the async FIFO; flags are computed against the
// read Gray pointer already synchronised into this clock domain, so they err toward full.
module wr_ptr_handler
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = 3,
    parameter int AF_THRESH = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic [PTR_WIDTH:0]   i_g_rd_ptr,
    input  logic                 i_clr_ovf,
    output logic [PTR_WIDTH:0]   o_b_wr_ptr,
    output logic [PTR_WIDTH:0]   o_g_wr_ptr,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [PTR_WIDTH:0]   o_wr_level,
    output logic                 o_overflow
);

    localparam int PW    = PTR_WIDTH + 1;
    localparam int DEPTH = depth_of(PTR_WIDTH);
    localparam logic [PTR_WIDTH:0] AF_V = PW'(AF_THRESH);

    if (PTR_WIDTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_param_check
        $error("wr_ptr_handler: illegal PTR_WIDTH/AF_THRESH combination");
    end

    logic [PTR_WIDTH:0] r_b_wr_ptr;
    logic [PTR_WIDTH:0] r_g_wr_ptr;
    logic               r_full;
    logic               r_almost_full;
    logic [PTR_WIDTH:0] r_wr_level;
    logic               r_overflow;

    logic               w_we;
    logic [PTR_WIDTH:0] w_nxt_b;
    logic [PTR_WIDTH:0] w_nxt_g;
    logic [PTR_WIDTH:0] w_rd_b;
    logic [PTR_WIDTH:0] w_lvl_n;
    logic               w_full_n;
    logic               w_af_n;

    gray2bin #(.W(PW)) u_rd_g2b (
        .i_gray (i_g_rd_ptr),
        .o_bin  (w_rd_b)
    );

    assign w_we    = i_en & ~r_full;
    assign w_nxt_b = r_b_wr_ptr + {{PTR_WIDTH{1'b0}}, w_we};
    assign w_nxt_g = PW'(bin2gray(32'(w_nxt_b)));

    // Full in Gray terms: top two bits inverted, remaining bits equal to the read pointer.
    assign w_full_n = (w_nxt_g == {~i_g_rd_ptr[PTR_WIDTH:PTR_WIDTH-1], i_g_rd_ptr[PTR_WIDTH-2:0]});
    assign w_lvl_n  = w_nxt_b - w_rd_b;
    assign w_af_n   = (w_lvl_n >= AF_V);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_b_wr_ptr    <= '0;
            r_g_wr_ptr    <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_b_wr_ptr    <= w_nxt_b;
            r_g_wr_ptr    <= w_nxt_g;
            r_full        <= w_full_n;
            r_almost_full <= w_af_n;
            r_wr_level    <= w_lvl_n;
            // A rejected write sets the sticky flag even when a clear is requested.
            if (i_en & r_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_b_wr_ptr    = r_b_wr_ptr;
    assign o_g_wr_ptr    = r_g_wr_ptr;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_wr_level    = r_wr_level;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_wr_ptr_handler.sv
// Bench for wr_ptr_handler: directed scenarios plus random traffic against an occupancy-count model.
module tb_wr_ptr_handler;

    logic       i_clk;
    logic       i_rstn;
    logic       i_en;
    logic [3:0] i_g_rd_ptr;
    logic       i_clr_ovf;
    logic [3:0] o_b_wr_ptr;
    logic [3:0] o_g_wr_ptr;
    logic       o_full;
    logic       o_almost_full;
    logic [3:0] o_wr_level;
    logic       o_overflow;

    int n_total;
    int n_bad;

    // Model: plain counts of words written and words read since reset.
    int m_wc;
    int m_rc;
    bit m_full;
    bit m_ovf;

    wr_ptr_handler #(.PTR_WIDTH(3), .AF_THRESH(6)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_en          (i_en),
        .i_g_rd_ptr    (i_g_rd_ptr),
        .i_clr_ovf     (i_clr_ovf),
        .o_b_wr_ptr    (o_b_wr_ptr),
        .o_g_wr_ptr    (o_g_wr_ptr),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_wr_level    (o_wr_level),
        .o_overflow    (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all(input string tag);
        int lvl;
        lvl = m_wc - m_rc;
        chk({tag, ".b_ptr"}, int'(o_b_wr_ptr), m_wc % 16);
        chk({tag, ".g_ptr"}, int'(o_g_wr_ptr), int'(to_gray(m_wc)));
        chk({tag, ".full"},  int'(o_full), (lvl == 8) ? 1 : 0);
        chk({tag, ".af"},    int'(o_almost_full), (lvl >= 6) ? 1 : 0);
        chk({tag, ".level"}, int'(o_wr_level), lvl);
        chk({tag, ".ovf"},   int'(o_overflow), m_ovf ? 1 : 0);
    endtask

    // One clock: drive inputs after the previous edge, advance the model at the edge, sample 1ns later.
    task automatic step(input logic en, input logic clr, input string tag);
        i_en       = en;
        i_clr_ovf  = clr;
        i_g_rd_ptr = to_gray(m_rc);
        @(posedge i_clk);
        if (en && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (en && !m_full) m_wc++;
        m_full = ((m_wc - m_rc) == 8);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge i_clk);
        #2;
        i_rstn = 1'b0;
        m_wc = 0; m_rc = 0; m_full = 1'b0; m_ovf = 1'b0;
        #1;
        chk({tag, ".b_ptr"}, int'(o_b_wr_ptr), 0);
        chk({tag, ".g_ptr"}, int'(o_g_wr_ptr), 0);
        chk({tag, ".full"},  int'(o_full), 0);
        chk({tag, ".af"},    int'(o_almost_full), 0);
        chk({tag, ".level"}, int'(o_wr_level), 0);
        chk({tag, ".ovf"},   int'(o_overflow), 0);
        i_en = 1'b0; i_clr_ovf = 1'b0; i_g_rd_ptr = 4'd0;
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] prev_g;
        n_total = 0; n_bad = 0;
        m_wc = 0; m_rc = 0; m_full = 1'b0; m_ovf = 1'b0;
        i_rstn = 1'b1; i_en = 1'b0; i_clr_ovf = 1'b0; i_g_rd_ptr = 4'd0;
        #7;

        // Reset takes effect without a clock edge.
        async_reset("reset");

        // Fill from empty: eight writes.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, "fill");
            if (k == 6) chk("fill.af_at6", int'(o_almost_full), 1);
            if (k == 5) chk("fill.af_at5", int'(o_almost_full), 0);
        end
        chk("fill.b8",    int'(o_b_wr_ptr), 8);
        chk("fill.g8",    int'(o_g_wr_ptr), 12);
        chk("fill.full8", int'(o_full), 1);
        chk("fill.lvl8",  int'(o_wr_level), 8);

        // Overflow: set, clear, and set-beats-clear.
        step(1'b1, 1'b0, "ovf_a");
        step(1'b1, 1'b0, "ovf_b");
        chk("ovf.b_hold", int'(o_b_wr_ptr), 8);
        chk("ovf.set",    int'(o_overflow), 1);
        step(1'b0, 1'b1, "ovf_clr");
        chk("ovf.cleared", int'(o_overflow), 0);
        step(1'b1, 1'b1, "ovf_both");
        chk("ovf.set_wins", int'(o_overflow), 1);

        // Read pointer advances by one while full.
        m_rc = 1;
        step(1'b0, 1'b0, "rd_adv");
        chk("rd_adv.full", int'(o_full), 0);
        chk("rd_adv.lvl",  int'(o_wr_level), 7);
        chk("rd_adv.af",   int'(o_almost_full), 1);
        step(1'b1, 1'b0, "refill");
        chk("refill.full", int'(o_full), 1);

        // Wrap: 16 writes while the reader keeps pace.
        async_reset("reset2");
        prev_g = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            m_rc = (m_wc > 0) ? m_wc - 1 : 0;
            step(1'b1, 1'b0, "wrap");
            chk("wrap.g_1bit", $countones(o_g_wr_ptr ^ prev_g), 1);
            chk("wrap.no_full", int'(o_full), 0);
            if (k == 15) chk("wrap.b15", int'(o_b_wr_ptr), 15);
            prev_g = o_g_wr_ptr;
        end
        chk("wrap.b0", int'(o_b_wr_ptr), 0);

        // Reset while full with overflow pending.
        m_rc = m_wc;
        for (int k = 0; k < 9; k++) step(1'b1, 1'b0, "prefull");
        chk("prefull.ovf", int'(o_overflow), 1);
        async_reset("reset3");
        step(1'b1, 1'b0, "post_rst");
        chk("post_rst.b1", int'(o_b_wr_ptr), 1);
        chk("post_rst.g1", int'(o_g_wr_ptr), 1);

        // Random traffic: reader advances by a legal amount, writer and clear requests random.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0 && m_rc < m_wc)
                m_rc += $urandom_range(1, m_wc - m_rc);
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
